cdc_event_sync_rx: RTL

//   Multi-channel receive side of the toggle-based pulse crossing. Each channel

---
 rtl/cdc_event_sync_rx.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cdc_event_sync_rx.sv
// Toggle-crossing receiver: synchronises per-channel toggles, pulses on edges, counts events (sat) for a round-robin drain.
// Pulse lands SYNC_STAGES+1 edges after capture; evt_valid holds its record until evt_ready, while counters keep accumulating.
`timescale 1ns/1ps
module cdc_event_sync_rx #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [CHANNELS-1:0]                        tog_in,
    output logic [CHANNELS-1:0]                        ack_tog,
    output logic [CHANNELS-1:0]                        pulse_out,
    output logic                                       evt_valid,
    input  logic                                       evt_ready,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] evt_chan,
    output logic [CNT_W-1:0]                           evt_count,
    output logic [CHANNELS-1:0]                        ovf,
    input  logic [CHANNELS-1:0]                        ovf_clr
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q;
    logic [CHANNELS-1:0] last_q;
    logic [CHANNELS-1:0] sync_last;
    logic [CHANNELS-1:0] tog_edge;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CH_W-1:0]     rr_q;
    logic [CH_W-1:0]     sel;
    logic [CH_W-1:0]     rr_next;
    logic                any_nz;
    logic                load;
    state_t              state;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sync_last[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    assign tog_edge = sync_last ^ last_q;
    assign ack_tog  = sync_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            last_q    <= '0;
            pulse_out <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], tog_in[i]};
            end
            last_q    <= sync_last;
            pulse_out <= tog_edge;
        end
    end

    // First nonzero counter at or after the round-robin pointer, wrapping.
    always_comb begin
        int idx;
        any_nz = 1'b0;
        sel    = '0;
        idx    = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = (int'(rr_q) + k) % CHANNELS;
            if (!any_nz && cnt_q[CH_W'(idx)] != '0) begin
                any_nz = 1'b1;
                sel    = CH_W'(idx);
            end
        end
    end

    assign rr_next = (sel == CH_W'(CHANNELS - 1)) ? '0 : sel + 1'b1;
    assign load    = any_nz && (state == S_IDLE || evt_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                // An edge coinciding with the snapshot starts the next record at 1.
                if (load && sel == CH_W'(i)) begin
                    cnt_q[i] <= tog_edge[i] ? CNT_W'(1) : '0;
                end else if (tog_edge[i] && cnt_q[i] != CNT_MAX) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end

                if (tog_edge[i] && cnt_q[i] == CNT_MAX && !(load && sel == CH_W'(i))) begin
                    ovf[i] <= 1'b1;
                end else if (ovf_clr[i]) begin
                    ovf[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            evt_valid <= 1'b0;
            evt_chan  <= '0;
            evt_count <= '0;
            rr_q      <= '0;
        end else if (load) begin
            state     <= S_OFFER;
            evt_valid <= 1'b1;
            evt_chan  <= sel;
            evt_count <= cnt_q[sel];
            rr_q      <= rr_next;
        end else if (state == S_OFFER && evt_ready) begin
            state     <= S_IDLE;
            evt_valid <= 1'b0;
        end
    end
endmodule
